// File: rtl/node_table_pkg.sv
// Shared constants and scan-state encoding for the node table bank.
package node_table_pkg;

    localparam int unsigned NT_WORD_WIDTH = 16;
    localparam int unsigned NT_DEPTH      = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_e;

endpackage

// File: rtl/node_table_bank_if.sv
// Access, clear and scan bus of the node table bank; master drives, slave is the table.
interface node_table_bank_if #(
    parameter int unsigned WORD_WIDTH = node_table_pkg::NT_WORD_WIDTH,
    parameter int unsigned DEPTH      = node_table_pkg::NT_DEPTH,
    parameter int unsigned ADDR_W     = $clog2(DEPTH)
);
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_index;
    logic [WORD_WIDTH-1:0] data_in;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_index;
    logic [WORD_WIDTH-1:0] data_out;
    logic                  rd_valid;
    logic                  clr;
    logic                  scan_start;
    logic                  busy;
    logic                  scan_done;
    logic [ADDR_W-1:0]     min_index;
    logic [WORD_WIDTH-1:0] min_value;
    logic                  min_found;
    logic                  wr_err;
    logic [ADDR_W:0]       valid_count;

    modport master (
        output wr_en, wr_index, data_in, rd_en, rd_index, clr, scan_start,
        input  data_out, rd_valid, busy, scan_done, min_index, min_value,
               min_found, wr_err, valid_count
    );

    modport slave (
        input  wr_en, wr_index, data_in, rd_en, rd_index, clr, scan_start,
        output data_out, rd_valid, busy, scan_done, min_index, min_value,
               min_found, wr_err, valid_count
    );
endinterface

// File: rtl/node_table_scan.sv
// Minimum-value scan FSM: walks every index once, tracks the smallest valid entry.
module node_table_scan
    import node_table_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = NT_WORD_WIDTH,
    parameter int unsigned DEPTH      = NT_DEPTH,
    parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  clr,
    input  logic                  scan_start,
    input  logic [WORD_WIDTH-1:0] scan_word,
    input  logic                  scan_vld,
    output logic [ADDR_W-1:0]     scan_idx,
    output logic                  busy,
    output logic                  scan_done,
    output logic [ADDR_W-1:0]     min_index,
    output logic [WORD_WIDTH-1:0] min_value,
    output logic                  min_found
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    scan_state_e           state_q, state_d;
    logic [ADDR_W-1:0]     idx_q, idx_d;
    logic [ADDR_W-1:0]     best_idx_q, best_idx_d;
    logic [WORD_WIDTH-1:0] best_val_q, best_val_d;
    logic                  best_found_q, best_found_d;
    logic [ADDR_W-1:0]     min_index_q, min_index_d;
    logic [WORD_WIDTH-1:0] min_value_q, min_value_d;
    logic                  min_found_q, min_found_d;
    logic                  busy_q, busy_d;
    logic                  scan_done_q, scan_done_d;
    logic                  take;

    // Strict less-than keeps the earliest index on ties.
    assign take = scan_vld && (!best_found_q || (scan_word < best_val_q));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        best_idx_d   = best_idx_q;
        best_val_d   = best_val_q;
        best_found_d = best_found_q;
        min_index_d  = min_index_q;
        min_value_d  = min_value_q;
        min_found_d  = min_found_q;

        if (clr) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_start) begin
                        state_d      = ST_SCAN;
                        idx_d        = '0;
                        best_idx_d   = '0;
                        best_val_d   = '0;
                        best_found_d = 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (take) begin
                        best_idx_d   = idx_q;
                        best_val_d   = scan_word;
                        best_found_d = 1'b1;
                    end
                    // Results commit from the post-update candidate on the final index.
                    if (idx_q == LAST_IDX) begin
                        state_d     = ST_DONE;
                        min_index_d = best_idx_d;
                        min_value_d = best_val_d;
                        min_found_d = best_found_d;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d      = (state_d != ST_IDLE);
        scan_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            best_idx_q   <= '0;
            best_val_q   <= '0;
            best_found_q <= 1'b0;
            min_index_q  <= '0;
            min_value_q  <= '0;
            min_found_q  <= 1'b0;
            busy_q       <= 1'b0;
            scan_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            best_idx_q   <= best_idx_d;
            best_val_q   <= best_val_d;
            best_found_q <= best_found_d;
            min_index_q  <= min_index_d;
            min_value_q  <= min_value_d;
            min_found_q  <= min_found_d;
            busy_q       <= busy_d;
            scan_done_q  <= scan_done_d;
        end
    end

    assign scan_idx  = idx_q;
    assign busy      = busy_q;
    assign scan_done = scan_done_q;
    assign min_index = min_index_q;
    assign min_value = min_value_q;
    assign min_found = min_found_q;

endmodule

// File: rtl/node_table_bank.sv
// Node table: word storage with valid bits, registered reads and a minimum-value scanner.
module node_table_bank
    import node_table_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = NT_WORD_WIDTH,
    parameter int unsigned DEPTH      = NT_DEPTH,
    parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             nrst,
    node_table_bank_if.slave bus
);

    logic [WORD_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [ADDR_W:0]       valid_count_q, valid_count_d;
    logic [WORD_WIDTH-1:0] data_out_q, data_out_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  wr_err_q, wr_err_d;
    logic                  mem_we;
    logic                  busy;
    logic [ADDR_W-1:0]     scan_idx;
    logic [WORD_WIDTH-1:0] scan_word;
    logic                  scan_vld;

    assign scan_word = mem_q[scan_idx];
    assign scan_vld  = valid_q[scan_idx];

    // A clear wins over a write; the dropped write is not an error.
    assign mem_we = nrst && bus.wr_en && !busy && !bus.clr;

    always_comb begin
        valid_d       = valid_q;
        valid_count_d = valid_count_q;
        data_out_d    = data_out_q;
        rd_valid_d    = 1'b0;
        wr_err_d      = busy && (bus.rd_en || (bus.wr_en && !bus.clr));

        if (bus.rd_en && !busy) begin
            data_out_d = mem_q[bus.rd_index];
            rd_valid_d = valid_q[bus.rd_index];
        end

        if (bus.clr) begin
            valid_d       = '0;
            valid_count_d = '0;
        end else if (mem_we) begin
            valid_d[bus.wr_index] = 1'b1;
            if (!valid_q[bus.wr_index]) begin
                valid_count_d = valid_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[bus.wr_index] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            valid_q       <= '0;
            valid_count_q <= '0;
            data_out_q    <= '0;
            rd_valid_q    <= 1'b0;
            wr_err_q      <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            valid_count_q <= valid_count_d;
            data_out_q    <= data_out_d;
            rd_valid_q    <= rd_valid_d;
            wr_err_q      <= wr_err_d;
        end
    end

    node_table_scan #(
        .WORD_WIDTH (WORD_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_scan (
        .clk        (clk),
        .nrst       (nrst),
        .clr        (bus.clr),
        .scan_start (bus.scan_start),
        .scan_word  (scan_word),
        .scan_vld   (scan_vld),
        .scan_idx   (scan_idx),
        .busy       (busy),
        .scan_done  (bus.scan_done),
        .min_index  (bus.min_index),
        .min_value  (bus.min_value),
        .min_found  (bus.min_found)
    );

    assign bus.busy        = busy;
    assign bus.data_out    = data_out_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.wr_err      = wr_err_q;
    assign bus.valid_count = valid_count_q;

endmodule

// File: tb/tb_node_table_bank.sv
// Randomized and directed checks of node_table_bank against an array-based reference model.
module tb_node_table_bank;

    localparam int unsigned W = 16;
    localparam int unsigned D = 64;
    localparam int unsigned A = $clog2(D);

    logic clk = 1'b0;
    logic nrst;

    always #5 clk = ~clk;

    node_table_bank_if #(.WORD_WIDTH(W), .DEPTH(D), .ADDR_W(A)) bus ();

    node_table_bank #(.WORD_WIDTH(W), .DEPTH(D), .ADDR_W(A)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference state: table contents, valid flags, and scan age in cycles since start.
    int unsigned m_mem [D];
    bit          m_vld [D];
    int unsigned m_dout, m_rv, m_err, m_age, m_mini, m_minv, m_minf;

    task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned count_valid();
        int unsigned c = 0;
        for (int i = 0; i < int'(D); i++) if (m_vld[i]) c++;
        return c;
    endfunction

    function automatic void compute_min();
        m_minf = 0; m_mini = 0; m_minv = 0;
        for (int i = 0; i < int'(D); i++) begin
            if (m_vld[i] && (m_minf == 0 || m_mem[i] < m_minv)) begin
                m_minf = 1; m_mini = i; m_minv = m_mem[i];
            end
        end
    endfunction

    function automatic void model_edge();
        bit busy;
        if (!nrst) begin
            for (int i = 0; i < int'(D); i++) m_vld[i] = 0;
            m_dout = 0; m_rv = 0; m_err = 0; m_age = 0;
            m_mini = 0; m_minv = 0; m_minf = 0;
            return;
        end
        busy  = (m_age != 0);
        m_err = (busy && (bus.rd_en || (bus.wr_en && !bus.clr))) ? 1 : 0;
        if (bus.rd_en && !busy) begin
            m_dout = m_mem[bus.rd_index];
            m_rv   = m_vld[bus.rd_index];
        end else begin
            m_rv = 0;
        end
        if (bus.clr) begin
            for (int i = 0; i < int'(D); i++) m_vld[i] = 0;
            m_age = 0;
        end else begin
            if (bus.wr_en && !busy) begin
                m_mem[bus.wr_index] = bus.data_in;
                m_vld[bus.wr_index] = 1;
            end
            if (m_age == 0) begin
                if (bus.scan_start) m_age = 1;
            end else if (m_age == D + 1) begin
                m_age = 0;
            end else begin
                m_age++;
                if (m_age == D + 1) compute_min();
            end
        end
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("data_out",    bus.data_out,    m_dout);
        chk("rd_valid",    bus.rd_valid,    m_rv);
        chk("wr_err",      bus.wr_err,      m_err);
        chk("busy",        bus.busy,        (m_age != 0) ? 1 : 0);
        chk("scan_done",   bus.scan_done,   (m_age == D + 1) ? 1 : 0);
        chk("valid_count", bus.valid_count, count_valid());
        chk("min_index",   bus.min_index,   m_mini);
        chk("min_value",   bus.min_value,   m_minv);
        chk("min_found",   bus.min_found,   m_minf);
    endtask

    task automatic idle_in();
        bus.wr_en = 0; bus.rd_en = 0; bus.clr = 0; bus.scan_start = 0;
    endtask

    task automatic do_write(input int unsigned idx, input int unsigned val);
        idle_in(); bus.wr_en = 1; bus.wr_index = A'(idx); bus.data_in = W'(val);
        step(); idle_in();
    endtask

    task automatic do_read(input int unsigned idx);
        idle_in(); bus.rd_en = 1; bus.rd_index = A'(idx);
        step(); idle_in();
    endtask

    task automatic do_clr();
        idle_in(); bus.clr = 1; step(); idle_in();
    endtask

    // Starts a scan and returns the cycle number (1 = cycle after the start edge) of scan_done.
    task automatic run_scan(output int unsigned done_cyc);
        idle_in(); bus.scan_start = 1; step(); idle_in();
        done_cyc = 1;
        while (!bus.scan_done && done_cyc < 3 * D) begin
            step(); done_cyc++;
        end
        if (!bus.scan_done) chk("scan_timeout", 0, 1);
        step();
    endtask

    initial begin
        int unsigned cyc;
        bit saw_done;
        nrst = 0;
        idle_in();
        bus.wr_index = '0; bus.rd_index = '0; bus.data_in = '0;
        for (int i = 0; i < int'(D); i++) begin m_mem[i] = 0; m_vld[i] = 0; end
        step(); step();
        chk("rst_busy", bus.busy, 0);
        chk("rst_vcnt", bus.valid_count, 0);
        nrst = 1;

        // Give every entry known contents, then invalidate all.
        for (int i = 0; i < int'(D); i++) do_write(i, $urandom_range(0, 65535));
        chk("full_vcnt", bus.valid_count, D);
        do_clr();
        chk("clr_vcnt", bus.valid_count, 0);

        do_write(0, 3); do_write(2, 15);
        do_read(2);
        chk("r2_dout", bus.data_out, 15);
        chk("r2_rv", bus.rd_valid, 1);
        do_read(1);
        chk("r1_rv", bus.rd_valid, 0);
        chk("vcnt2", bus.valid_count, 2);
        do_write(2, 16);
        chk("rewrite_vcnt", bus.valid_count, 2);

        do_clr();
        do_write(5, 40); do_write(9, 7); do_write(12, 7);
        run_scan(cyc);
        chk("scan_latency", cyc, D + 1);
        chk("s1_idx", bus.min_index, 9);
        chk("s1_val", bus.min_value, 7);
        chk("s1_found", bus.min_found, 1);

        do_clr();
        run_scan(cyc);
        chk("s2_found", bus.min_found, 0);
        chk("s2_idx", bus.min_index, 0);
        chk("s2_val", bus.min_value, 0);
        chk("s2_vcnt", bus.valid_count, 0);

        do_write(3, 33);
        idle_in(); bus.scan_start = 1; step(); idle_in();
        do_write(3, 99);
        chk("busy_wr_err", bus.wr_err, 1);
        step();
        chk("wr_err_pulse", bus.wr_err, 0);
        while (bus.busy) step();
        do_read(3);
        chk("r3_kept", bus.data_out, 33);

        do_write(4, 20);
        idle_in(); bus.wr_en = 1; bus.wr_index = 4; bus.data_in = 8;
        bus.rd_en = 1; bus.rd_index = 4; step(); idle_in();
        chk("rbw_old", bus.data_out, 20);
        do_read(4);
        chk("rbw_new", bus.data_out, 8);

        idle_in(); bus.scan_start = 1; step(); idle_in();
        for (int i = 0; i < 9; i++) step();
        nrst = 0; step(); nrst = 1;
        chk("rst_mid_busy", bus.busy, 0);
        chk("rst_mid_vcnt", bus.valid_count, 0);
        chk("rst_mid_dout", bus.data_out, 0);
        saw_done = 0;
        for (int i = 0; i < int'(D) + 4; i++) begin
            step();
            if (bus.scan_done) saw_done = 1;
        end
        chk("rst_no_done", saw_done, 0);

        // Random traffic: accesses, scans, clears and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            nrst           = ($urandom_range(0, 299) != 0);
            bus.wr_en      = $urandom_range(0, 1);
            bus.rd_en      = $urandom_range(0, 1);
            bus.wr_index   = A'($urandom_range(0, D - 1));
            bus.rd_index   = A'($urandom_range(0, D - 1));
            bus.data_in    = W'($urandom_range(0, 31));
            bus.clr        = ($urandom_range(0, 79) == 0);
            bus.scan_start = ($urandom_range(0, 29) == 0);
            step();
        end
        nrst = 1;
        idle_in();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
